// File: rtl/xor_cipher_pkg.sv
// xor_cipher_pkg: shared sequencer state encoding and default geometry for the cipher key path
package xor_cipher_pkg;
  localparam int KEY_W_DEF = 32;
  localparam int HB_W_DEF = 3;
  localparam int HB_DIV_DEF = 16;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_RUN, S_ERR} state_e;
endpackage

// File: rtl/xor_cipher_key_shifter.sv
// xor_cipher_key_shifter: key shadow, MSB-first bit serialiser and readback comparator
module xor_cipher_key_shifter import xor_cipher_pkg::*; #(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key,
  input  logic             shift,
  input  logic             phase,
  input  logic             ret,
  output logic             bit_out,
  output logic             last_bit,
  output logic             mismatch
);
  localparam int CW = $clog2(KEY_W);
  localparam logic [CW-1:0] LAST = CW'(KEY_W - 1);
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bit_q, bit_d, chk_q, chk_d, mis_q, mis_d;
  // chk_q marks that bit_q is a readback bit, so ret is compared against it on the following edge
  always_comb begin
    last_bit = cnt_q == LAST;
    mismatch = mis_q | (chk_q & (ret ^ bit_q));
    shadow_d = load ? key : shadow_q;
    cnt_d = load ? '0 : shift ? (last_bit ? '0 : cnt_q + CW'(1)) : cnt_q;
    bit_d = shift & shadow_q[LAST - cnt_q];
    chk_d = shift & phase;
    mis_d = ~load & mismatch;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      cnt_q <= '0;
      bit_q <= 1'b0;
      chk_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      chk_q <= chk_d;
      mis_q <= mis_d;
    end
  end
  assign bit_out = bit_q;
endmodule

// File: rtl/xor_cipher_key_sequencer.sv
// xor_cipher_key_sequencer: loads and verifies the core key chain, then gates tx/rx enables
module xor_cipher_key_sequencer import xor_cipher_pkg::*; #(
  parameter int KEY_W = KEY_W_DEF,
  parameter int HB_W = HB_W_DEF,
  parameter int HB_DIV = HB_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic             tx_req,
  input  logic             rx_req,
  input  logic             cfg_ret,
  output logic             cfg_en,
  output logic             cfg_i,
  output logic             tx_en,
  output logic             rx_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [HB_W-1:0]  heartbeat
);
  localparam int PW = HB_DIV > 1 ? $clog2(HB_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(HB_DIV - 1);
  state_e state_q, state_d;
  logic tail_q, tail_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic tx_q, tx_d, rx_q, rx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [HB_W-1:0] hb_q, hb_d;
  logic accept, verify, shifting, finish, bit_out, last_bit, mismatch;
  xor_cipher_key_shifter #(.KEY_W(KEY_W)) u_shifter (
    .clk(clk),
    .rst_n(rst_n),
    .load(accept),
    .key(key),
    .shift(shifting),
    .phase(verify),
    .ret(cfg_ret),
    .bit_out(bit_out),
    .last_bit(last_bit),
    .mismatch(mismatch)
  );
  // VERIFY holds one extra tail cycle so the final readback bit is judged before leaving
  always_comb begin
    accept = start & (state_q inside {S_IDLE, S_RUN, S_ERR});
    verify = state_q == S_VERIFY;
    shifting = (state_q == S_LOAD) | (verify & ~tail_q);
    finish = verify & tail_q;
    state_d = accept ? S_LOAD :
              (state_q == S_LOAD && last_bit) ? S_VERIFY :
              finish ? (mismatch ? S_ERR : S_RUN) : state_q;
    tail_d = verify & ~tail_q & last_bit;
    busy_d = shifting;
    done_d = finish & ~mismatch;
    err_d = finish ? mismatch : err_q & ~accept;
    tx_d = (state_q == S_RUN) & ~accept & tx_req;
    rx_d = (state_q == S_RUN) & ~accept & rx_req;
    pre_d = pre_q == PRE_LAST ? '0 : pre_q + PW'(1);
    hb_d = pre_q == PRE_LAST ? hb_q + HB_W'(1) : hb_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tail_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      tx_q <= 1'b0;
      rx_q <= 1'b0;
      pre_q <= '0;
      hb_q <= '0;
    end else begin
      state_q <= state_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      pre_q <= pre_d;
      hb_q <= hb_d;
    end
  end
  assign cfg_en = busy_q;
  assign busy = busy_q;
  assign cfg_i = bit_out;
  assign done = done_q;
  assign err = err_q;
  assign tx_en = tx_q;
  assign rx_en = rx_q;
  assign heartbeat = hb_q;
endmodule

// File: tb/tb_xor_cipher_key_sequencer.sv
// tb_xor_cipher_key_sequencer: directed bench with a cycle-offset model of the key sequencer and core chain
module tb_xor_cipher_key_sequencer;
  localparam int K = 32;
  logic clk = 0, rst_n = 0, start = 0, tx_req = 0, rx_req = 0, cfg_ret;
  logic [K-1:0] key = '0;
  logic cfg_en, cfg_i, tx_en, rx_en, busy, done, err;
  logic [2:0] heartbeat;
  logic [K-1:0] chain = '0;
  int tests = 0, fails = 0;
  bit chk_on = 0, inject = 0;
  int t = -1, hb_cyc = 0;
  bit bad = 0, m_err = 0;
  logic [K-1:0] sk = '0;
  logic e_en = 0, e_bit = 0, e_done = 0, e_err = 0, e_tx = 0, e_rx = 0;
  logic [2:0] e_hb = 0;
  int d, b;
  logic tx0;
  assign cfg_ret = chain[K-1];
  always #5 clk = ~clk;
  xor_cipher_key_sequencer #(.KEY_W(K), .HB_W(3), .HB_DIV(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key(key),
    .tx_req(tx_req),
    .rx_req(rx_req),
    .cfg_ret(cfg_ret),
    .cfg_en(cfg_en),
    .cfg_i(cfg_i),
    .tx_en(tx_en),
    .rx_en(rx_en),
    .busy(busy),
    .done(done),
    .err(err),
    .heartbeat(heartbeat)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // t counts edges since the accepted start; the core chain reacts to the real pins
  always @(posedge clk or negedge rst_n) begin : model
    logic [K-1:0] nc;
    bit acc, run_prev;
    if (!rst_n) begin
      t = -1; bad = 0; m_err = 0; hb_cyc = 0;
      e_en = 0; e_bit = 0; e_done = 0; e_err = 0; e_tx = 0; e_rx = 0; e_hb = 0;
    end else begin
      nc = cfg_en ? {chain[K-2:0], cfg_i} : chain;
      acc = start && !(t >= 0 && t <= 2*K);
      run_prev = t >= 2*K+1 && !bad;
      e_tx = run_prev && !acc && tx_req;
      e_rx = run_prev && !acc && rx_req;
      if (acc) begin
        t = 0; sk = key; bad = 0; m_err = 0;
      end else if (t >= 0 && t < 1000) t++;
      if (t == K+1) begin
        if (inject) nc[7] = ~nc[7];
        bad = nc != sk;
      end
      e_en = t >= 1 && t <= 2*K;
      e_bit = e_en && sk[K-1-((t-1)%K)];
      e_done = t == 2*K+1 && !bad;
      if (t == 2*K+1 && bad) m_err = 1;
      e_err = m_err;
      hb_cyc = (hb_cyc + 1) % 128;
      e_hb = 3'(hb_cyc / 16);
      chain <= nc;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("cfg_en", cfg_en, e_en);
    chk("busy", busy, e_en);
    chk("cfg_i", cfg_i, e_bit);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("tx_en", tx_en, e_tx);
    chk("rx_en", rx_en, e_rx);
    chk("heartbeat", heartbeat, e_hb);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [K-1:0] k, input int pulse_at, output int done_at, output int busy_n, output logic tx_first);
    start = 1; key = k; done_at = -1; busy_n = 0;
    @(posedge clk); #1;
    start = 0;
    tx_first = tx_en;
    for (int e = 1; e <= 80; e++) begin
      if (e == pulse_at) begin start = 1; key = ~k; end
      @(posedge clk); #1;
      start = 0;
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = e;
    end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cfg_en", cfg_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hb", heartbeat, 0);
    chk_on = 1;
    rst_n = 1;
    tick(15); chk("hb_c15", heartbeat, 0);
    tick(1); chk("hb_c16", heartbeat, 1);
    tick(111); chk("hb_c127", heartbeat, 7);
    tick(1); chk("hb_c128", heartbeat, 0);
    do_load(32'hA5C3_0F96, 0, d, b, tx0);
    chk("t1_done_edge", d, 65);
    chk("t1_busy_cycles", b, 64);
    chk("t1_chain", chain, 32'hA5C3_0F96);
    chk("t1_err", err, 0);
    tx_req = 1; rx_req = 0;
    chk("t3_tx_before", tx_en, 0);
    tick(1);
    chk("t3_tx_after", tx_en, 1);
    chk("t3_rx_low", rx_en, 0);
    rx_req = 1;
    tick(1);
    chk("t3_rx_after", rx_en, 1);
    chk("t3_tx_hold", tx_en, 1);
    inject = 1;
    do_load(32'h1234_5678, 0, d, b, tx0);
    chk("t2_start_wins", tx0, 0);
    chk("t2_no_done", d, -1);
    chk("t2_err", err, 1);
    chk("t2_tx_in_err", tx_en, 0);
    inject = 0;
    do_load(32'h0F0F_3C3C, 0, d, b, tx0);
    chk("t2_retry_done", d, 65);
    chk("t2_retry_err", err, 0);
    chk("t2_retry_chain", chain, 32'h0F0F_3C3C);
    do_load(32'hDEAD_BEEF, 11, d, b, tx0);
    chk("t4_done_edge", d, 65);
    chk("t4_busy_cycles", b, 64);
    chk("t4_chain", chain, 32'hDEAD_BEEF);
    start = 1; key = 32'h6A6A_9595;
    tick(1);
    start = 0;
    tick(37);
    #2 rst_n = 0;
    #1;
    chk("t5_cfg_en", cfg_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_cfg_i", cfg_i, 0);
    chk("t5_done", done, 0);
    chk("t5_err", err, 0);
    chk("t5_tx", tx_en, 0);
    chk("t5_rx", rx_en, 0);
    chk("t5_hb", heartbeat, 0);
    tick(2);
    rst_n = 1;
    do_load(32'h6A6A_9595, 0, d, b, tx0);
    chk("t5_done_edge", d, 65);
    chk("t5_err_after", err, 0);
    chk("t5_chain", chain, 32'h6A6A_9595);
    tx_req = 0; rx_req = 0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
